mips32_mem_arbiter: RTL and testbench

Single-port memory arbiter for the 5-stage MIPS32 pipeline: shares one 1024x32 unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (LW/SW). Accepts one request at a time via valid/ready, sequences a fixed-latency memory access, and returns a one-cycle response pulse to the owning requester. Sits between the pipeline stage registers and the memory array; the hazard/stall logic uses `busy` and the ready signals to hold IF and MEM.

---
 rtl/mips32_mem_arbiter_pkg.sv | 37 +++
 rtl/mips32_mem_arbiter_if.sv | 56 +++++
 rtl/mips32_arb_starve_guard.sv | 47 ++++
 rtl/mips32_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_mem_arbiter_pkg.sv
// mips32_pkg -- shared definitions for the MIPS32 unified-memory arbiter.
//
// Contents:
//   ADDR_W / DATA_W : default word-address and data widths of the 1024x32 memory
//   arb_state_t     : arbiter FSM states (IDLE, ACCESS, RESP)
//   owner_t         : which requester owns the transaction in flight
//                     (OWN_IF = instruction fetch, OWN_D = data load/store)
//   store_data()    : data a requester is allowed to put on the write bus
package mips32_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   // Loads and fetches never drive write data; only a store passes its data on.
   function automatic logic [DATA_W-1:0] store_data(input logic we,
                                                     input logic [DATA_W-1:0] wdata);
      logic [DATA_W-1:0] res;
      if (we) begin
         res = wdata;
      end else begin
         res = {DATA_W{1'b0}};
      end
      return res;
   endfunction

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if -- bundle of the fetch port, data port and memory port
// of the unified-memory arbiter.
//
// Modports:
//   slave  : the arbiter side (takes requests and mem_rdata, returns
//            ready/response strobes and drives the memory bus)
//   master : the pipeline/memory side (the reverse directions)
//
// Signals:
//   if_req_valid/if_req_ready/if_addr/if_rsp_valid/if_rsp_data : instruction fetch
//   d_req_valid/d_req_ready/d_we/d_addr/d_wdata/d_rsp_valid/d_rsp_data : LW/SW
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : single-port memory array
interface mips32_mem_arbiter_if #(
   parameter int ADDR_W = mips32_pkg::ADDR_W,
   parameter int DATA_W = mips32_pkg::DATA_W
);

   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_rsp_valid;
   logic [DATA_W-1:0] if_rsp_data;

   logic              d_req_valid;
   logic              d_req_ready;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_rsp_valid;
   logic [DATA_W-1:0] d_rsp_data;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req_valid, if_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      input  d_req_valid, d_we, d_addr, d_wdata,
      output d_req_ready, d_rsp_valid, d_rsp_data,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output if_req_valid, if_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      output d_req_valid, d_we, d_addr, d_wdata,
      input  d_req_ready, d_rsp_valid, d_rsp_data,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/mips32_arb_starve_guard.sv
// mips32_arb_starve_guard -- anti-starvation helper for the memory arbiter.
//
// Counts consecutive data grants that were made while a fetch was also
// waiting. Once that streak reaches STARVE_MAX, force_if tells the arbiter to
// let the fetch win the next contested arbitration. Any fetch grant clears it.
//
// Ports:
//   clk1              in  clock
//   rst               in  synchronous active-high reset (clears the streak)
//   d_grant_contested in  data request accepted while if_req_valid was high
//   if_grant          in  fetch request accepted
//   force_if          out fetch must win when both requesters are valid
module mips32_arb_starve_guard #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk1,
   input  logic rst,
   input  logic d_grant_contested,
   input  logic if_grant,
   output logic force_if
);

   localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

   logic [3:0] streak_r;
   logic       at_max_r;

   // Streak counter; at_max_r is kept registered so force_if is a flop output.
   always_ff @(posedge clk1) begin
      if (rst) begin
         streak_r <= 4'd0;
         at_max_r <= 1'b0;
      end else if (if_grant) begin
         streak_r <= 4'd0;
         at_max_r <= 1'b0;
      end else if (d_grant_contested && !at_max_r) begin
         streak_r <= streak_r + 4'd1;
         at_max_r <= ((streak_r + 4'd1) == MAX_C);
      end else begin
         streak_r <= streak_r;
         at_max_r <= at_max_r;
      end
   end

   assign force_if = at_max_r;

endmodule

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter -- single-port memory arbiter between the IF stage and the
// MEM stage of the 5-stage MIPS32 pipeline.
//
// One request is accepted at a time (valid/ready). Data requests beat fetches
// when both are valid. The accepted access is issued to memory for one cycle,
// read data is captured MEM_LAT cycles after acceptance, and the owner gets a
// one-cycle response strobe. busy is high whenever the FSM is not IDLE.
//
// Ports:
//   clk1  in   clock, rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of mips32_mem_arbiter_if (fetch, data and memory ports)
//   busy  out  transaction in flight (state != IDLE)
//
// Build option: define MIPS32_ARB_STARVE_GUARD_EN to instantiate
// mips32_arb_starve_guard, which forces a fetch grant after STARVE_MAX
// consecutive contested data grants. Without it, data priority is strict.
module mips32_mem_arbiter #(
   parameter int ADDR_W     = mips32_pkg::ADDR_W,
   parameter int DATA_W     = mips32_pkg::DATA_W,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk1,
   input  logic                 rst,
   mips32_mem_arbiter_if.slave  bus,
   output logic                 busy
);

   import mips32_pkg::*;

   localparam logic [2:0] LAT_C = 3'(MEM_LAT);

   arb_state_t        state_r;
   logic [2:0]        cnt_r;
   owner_t            owner_r;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              mem_en_r;
   logic              if_rsp_valid_r;
   logic              d_rsp_valid_r;
   logic [DATA_W-1:0] if_rsp_data_r;
   logic [DATA_W-1:0] d_rsp_data_r;

   logic              idle_s;
   logic              grant_if_s;
   logic              if_acc_s;
   logic              d_acc_s;
   logic              force_if_s;

`ifdef MIPS32_ARB_STARVE_GUARD_EN
   logic              d_contested_s;

   assign d_contested_s = d_acc_s & bus.if_req_valid;

   mips32_arb_starve_guard #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_guard (
      .clk1              (clk1),
      .rst               (rst),
      .d_grant_contested (d_contested_s),
      .if_grant          (if_acc_s),
      .force_if          (force_if_s)
   );
`else
   assign force_if_s = 1'b0;
`endif

   // Arbitration: ready goes only to the winner, only in IDLE and out of reset,
   // so a request presented in the cycle rst drops is accepted that cycle.
   always_comb begin
      idle_s     = 1'b0;
      grant_if_s = 1'b0;
      if_acc_s   = 1'b0;
      d_acc_s    = 1'b0;
      if ((state_r == IDLE) && !rst) begin
         idle_s = 1'b1;
      end else begin
         idle_s = 1'b0;
      end
      if (bus.if_req_valid && (!bus.d_req_valid || force_if_s)) begin
         grant_if_s = 1'b1;
      end else begin
         grant_if_s = 1'b0;
      end
      if (idle_s) begin
         if_acc_s = grant_if_s;
         d_acc_s  = bus.d_req_valid & ~grant_if_s;
      end else begin
         if_acc_s = 1'b0;
         d_acc_s  = 1'b0;
      end
   end

   // Transaction FSM with capture registers, latency counter and response regs.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state_r        <= IDLE;
         cnt_r          <= 3'd0;
         owner_r        <= OWN_IF;
         we_r           <= 1'b0;
         addr_r         <= {ADDR_W{1'b0}};
         wdata_r        <= {DATA_W{1'b0}};
         mem_en_r       <= 1'b0;
         if_rsp_valid_r <= 1'b0;
         d_rsp_valid_r  <= 1'b0;
         if_rsp_data_r  <= {DATA_W{1'b0}};
         d_rsp_data_r   <= {DATA_W{1'b0}};
      end else begin
         // Strobes are single-cycle unless re-set below.
         mem_en_r       <= 1'b0;
         if_rsp_valid_r <= 1'b0;
         d_rsp_valid_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (d_acc_s) begin
                  state_r  <= ACCESS;
                  cnt_r    <= 3'd1;
                  mem_en_r <= 1'b1;
                  owner_r  <= OWN_D;
                  we_r     <= bus.d_we;
                  addr_r   <= bus.d_addr;
                  wdata_r  <= store_data(bus.d_we, bus.d_wdata);
               end else if (if_acc_s) begin
                  state_r  <= ACCESS;
                  cnt_r    <= 3'd1;
                  mem_en_r <= 1'b1;
                  owner_r  <= OWN_IF;
                  we_r     <= 1'b0;
                  addr_r   <= bus.if_addr;
                  wdata_r  <= {DATA_W{1'b0}};
               end else begin
                  state_r  <= IDLE;
               end
            end
            ACCESS: begin
               // cnt_r numbers the ACCESS cycles 1..MEM_LAT; the last one samples memory.
               if (cnt_r == LAT_C) begin
                  state_r <= RESP;
                  cnt_r   <= 3'd0;
                  if (owner_r == OWN_D) begin
                     d_rsp_valid_r <= 1'b1;
                     d_rsp_data_r  <= we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
                  end else begin
                     if_rsp_valid_r <= 1'b1;
                     if_rsp_data_r  <= bus.mem_rdata;
                  end
               end else begin
                  cnt_r <= cnt_r + 3'd1;
               end
            end
            RESP: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= 3'd0;
            end
         endcase
      end
   end

   // The memory bus is quiet (all zero) whenever mem_en is low.
   assign bus.mem_en    = mem_en_r;
   assign bus.mem_we    = mem_en_r & we_r;
   assign bus.mem_addr  = mem_en_r ? addr_r  : {ADDR_W{1'b0}};
   assign bus.mem_wdata = mem_en_r ? wdata_r : {DATA_W{1'b0}};

   assign bus.if_req_ready = if_acc_s;
   assign bus.d_req_ready  = d_acc_s;
   assign bus.if_rsp_valid = if_rsp_valid_r;
   assign bus.if_rsp_data  = if_rsp_data_r;
   assign bus.d_rsp_valid  = d_rsp_valid_r;
   assign bus.d_rsp_data   = d_rsp_data_r;

   assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter -- directed, table-driven bench for mips32_mem_arbiter.
// dut uses MEM_LAT=2, dut1 uses MEM_LAT=1; each has its own memory model whose
// read data follows the address most recently presented with mem_en.
module tb_mips32_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   logic rst;
   logic busy;
   logic busy1;
   logic mem_load;

   mips32_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mips32_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   mips32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   mips32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus1),
      .busy (busy1)
   );

   // Memory models
   logic [DW-1:0] mem  [0:1023];
   logic [DW-1:0] mem1 [0:1023];
   logic [AW-1:0] hold_a  = '0;
   logic [AW-1:0] hold_a1 = '0;

   always @(posedge clk1) begin
      if (mem_load) begin
         for (int i = 0; i < 1024; i++) begin
            mem[i]  <= 32'hA000_0000 | 32'(i);
            mem1[i] <= 32'hA000_0000 | 32'(i);
         end
         mem[5] <= 32'h2800_000A;
      end else begin
         if (bus.mem_en) begin
            hold_a <= bus.mem_addr;
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         end
         if (bus1.mem_en) begin
            hold_a1 <= bus1.mem_addr;
            if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
         end
      end
   end

   assign bus.mem_rdata  = mem[bus.mem_en ? bus.mem_addr : hold_a];
   assign bus1.mem_rdata = mem1[bus1.mem_en ? bus1.mem_addr : hold_a1];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   typedef struct {
      logic          is_d;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_data;
   } vec_t;

   vec_t vecs [7];

   // One isolated transaction on dut: accept at t, mem_en at t+1, RESP at t+3.
   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      if (v.is_d) begin
         bus.d_req_valid = 1'b1;
         bus.d_we        = v.we;
         bus.d_addr      = v.addr;
         bus.d_wdata     = v.wdata;
      end else begin
         bus.if_req_valid = 1'b1;
         bus.if_addr      = v.addr;
      end
      #1;
      chk($sformatf("%s_ready", tag), v.is_d ? bus.d_req_ready : bus.if_req_ready, 32'd1);
      chk($sformatf("%s_other_ready", tag), v.is_d ? bus.if_req_ready : bus.d_req_ready, 32'd0);
      step();
      bus.if_req_valid = 1'b0;
      bus.d_req_valid  = 1'b0;
      bus.d_wdata      = 32'h5555_5555;
      chk($sformatf("%s_mem_en", tag), bus.mem_en, 32'd1);
      chk($sformatf("%s_mem_addr", tag), bus.mem_addr, 32'(v.addr));
      chk($sformatf("%s_mem_we", tag), bus.mem_we, 32'(v.we));
      chk($sformatf("%s_mem_wdata", tag), bus.mem_wdata, v.we ? v.wdata : 32'd0);
      chk($sformatf("%s_busy1", tag), busy, 32'd1);
      step();
      chk($sformatf("%s_mem_en_off", tag), bus.mem_en, 32'd0);
      chk($sformatf("%s_mem_addr_off", tag), bus.mem_addr, 32'd0);
      chk($sformatf("%s_rsp_early", tag), {bus.if_rsp_valid, bus.d_rsp_valid}, 32'd0);
      step();
      chk($sformatf("%s_rsp_valid", tag), v.is_d ? bus.d_rsp_valid : bus.if_rsp_valid, 32'd1);
      chk($sformatf("%s_other_rsp", tag), v.is_d ? bus.if_rsp_valid : bus.d_rsp_valid, 32'd0);
      chk($sformatf("%s_rsp_data", tag), v.is_d ? bus.d_rsp_data : bus.if_rsp_data, v.exp_data);
      chk($sformatf("%s_busy_resp", tag), busy, 32'd1);
      step();
      chk($sformatf("%s_rsp_end", tag), {bus.if_rsp_valid, bus.d_rsp_valid}, 32'd0);
      chk($sformatf("%s_idle", tag), busy, 32'd0);
   endtask

   initial begin
      int  n_grants;
      logic exp_if;

      vecs[0] = '{1'b0, 1'b0, 10'h005, 32'h0000_0000, 32'h2800_000A};
      vecs[1] = '{1'b1, 1'b1, 10'h010, 32'h1234_5678, 32'h0000_0000};
      vecs[2] = '{1'b1, 1'b0, 10'h010, 32'h0000_0000, 32'h1234_5678};
      vecs[3] = '{1'b0, 1'b0, 10'h000, 32'h0000_0000, 32'hA000_0000};
      vecs[4] = '{1'b1, 1'b0, 10'h3FF, 32'h0000_0000, 32'hA000_03FF};
      vecs[5] = '{1'b1, 1'b1, 10'h000, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[6] = '{1'b0, 1'b0, 10'h000, 32'h0000_0000, 32'hFFFF_FFFF};

      mem_load = 1'b1;
      rst = 1'b1;
      bus.if_req_valid = 1'b1;  bus.if_addr = 10'h005;
      bus.d_req_valid  = 1'b1;  bus.d_we = 1'b0;  bus.d_addr = 10'h010;  bus.d_wdata = 32'h0;
      bus1.if_req_valid = 1'b1; bus1.if_addr = 10'h000;
      bus1.d_req_valid  = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = 10'h000; bus1.d_wdata = 32'h0;

      // Reset held 3 cycles with both requesters valid
      for (int c = 0; c < 3; c++) begin
         step();
         mem_load = 1'b0;
         chk($sformatf("rst%0d_ready", c), {bus.if_req_ready, bus.d_req_ready}, 32'd0);
         chk($sformatf("rst%0d_rsp", c), {bus.if_rsp_valid, bus.d_rsp_valid}, 32'd0);
         chk($sformatf("rst%0d_mem_en", c), bus.mem_en, 32'd0);
         chk($sformatf("rst%0d_busy", c), {busy, busy1}, 32'd0);
      end
      rst = 1'b0;
      bus.if_req_valid = 1'b0;
      bus.d_req_valid  = 1'b0;
      bus1.if_req_valid = 1'b0;
      step();

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], i);
      end

      // Simultaneous store vs fetch: data wins, fetch follows in the next IDLE
      bus.if_req_valid = 1'b1; bus.if_addr = 10'h005;
      bus.d_req_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h3FF; bus.d_wdata = 32'hDEAD_BEEF;
      #1;
      chk("sim_d_ready", bus.d_req_ready, 32'd1);
      chk("sim_if_ready", bus.if_req_ready, 32'd0);
      step();
      bus.d_req_valid = 1'b0; bus.d_we = 1'b0;
      chk("sim_mem_en", bus.mem_en, 32'd1);
      chk("sim_mem_we", bus.mem_we, 32'd1);
      chk("sim_mem_addr", bus.mem_addr, 32'h3FF);
      chk("sim_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("sim_if_ready_busy", bus.if_req_ready, 32'd0);
      step();
      step();
      chk("sim_d_rsp_valid", bus.d_rsp_valid, 32'd1);
      chk("sim_d_rsp_data", bus.d_rsp_data, 32'h0);
      chk("sim_if_ready_resp", bus.if_req_ready, 32'd0);
      step();
      chk("sim_if_ready_next", bus.if_req_ready, 32'd1);
      step();
      bus.if_req_valid = 1'b0;
      step();
      step();
      chk("sim_if_rsp_valid", bus.if_rsp_valid, 32'd1);
      chk("sim_if_rsp_data", bus.if_rsp_data, 32'h2800_000A);
      step();

      // Starvation: both held valid for 40 cycles
      bus.if_req_valid = 1'b1; bus.if_addr = 10'h005;
      bus.d_req_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h020;
      n_grants = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (bus.d_req_ready || bus.if_req_ready) begin
`ifdef MIPS32_ARB_STARVE_GUARD_EN
            exp_if = ((n_grants % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            chk($sformatf("starve_grant%0d_is_if", n_grants), bus.if_req_ready, 32'(exp_if));
            n_grants++;
         end
         @(posedge clk1);
         #1;
      end
      chk("starve_grant_count", n_grants, 32'd10);
      bus.if_req_valid = 1'b0;
      bus.d_req_valid  = 1'b0;
      for (int c = 0; c < 8 && busy; c++) step();
      chk("starve_drained", busy, 32'd0);
      step();

      // Reset during ACCESS: load dropped, pending fetch accepted right after
      bus.d_req_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h010;
      #1;
      chk("rmo_d_ready", bus.d_req_ready, 32'd1);
      step();
      bus.d_req_valid = 1'b0;
      bus.if_req_valid = 1'b1; bus.if_addr = 10'h005;
      rst = 1'b1;
      chk("rmo_busy_before", busy, 32'd1);
      step();
      rst = 1'b0;
      #1;
      chk("rmo_busy", busy, 32'd0);
      chk("rmo_d_rsp", bus.d_rsp_valid, 32'd0);
      chk("rmo_mem_en", bus.mem_en, 32'd0);
      chk("rmo_if_ready", bus.if_req_ready, 32'd1);
      step();
      bus.if_req_valid = 1'b0;
      chk("rmo_fetch_mem_en", bus.mem_en, 32'd1);
      chk("rmo_fetch_addr", bus.mem_addr, 32'h005);
      chk("rmo_d_rsp2", bus.d_rsp_valid, 32'd0);
      step();
      chk("rmo_d_rsp3", bus.d_rsp_valid, 32'd0);
      step();
      chk("rmo_if_rsp_valid", bus.if_rsp_valid, 32'd1);
      chk("rmo_if_rsp_data", bus.if_rsp_data, 32'h2800_000A);
      chk("rmo_d_rsp4", bus.d_rsp_valid, 32'd0);
      step();

      // MEM_LAT=1: continuous fetches 0..3 accepted every 3 cycles, in order
      bus1.if_req_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus1.if_addr = 10'(k);
         #1;
         chk($sformatf("lat1_%0d_ready", k), bus1.if_req_ready, 32'd1);
         step();
         bus1.if_addr = 10'(k + 1);
         chk($sformatf("lat1_%0d_mem_en", k), bus1.mem_en, 32'd1);
         chk($sformatf("lat1_%0d_mem_addr", k), bus1.mem_addr, 32'(k));
         chk($sformatf("lat1_%0d_ready_acc", k), bus1.if_req_ready, 32'd0);
         step();
         chk($sformatf("lat1_%0d_rsp_valid", k), bus1.if_rsp_valid, 32'd1);
         chk($sformatf("lat1_%0d_rsp_data", k), bus1.if_rsp_data, 32'hA000_0000 | 32'(k));
         chk($sformatf("lat1_%0d_ready_resp", k), bus1.if_req_ready, 32'd0);
         step();
      end
      bus1.if_req_valid = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
